jparam_ram: RTL and testbench
=============================

// Module: jparam_ram
// PURPOSE
//  Parametrised clocked RAM with on-chip memory address register (MAR), the successor to the single-byte register.
//  Holds DEPTH words of WIDTH bits. MAR is loaded from the input bus, then the addressed word is written from the bus or driven onto it.
//  Sits on the CPU data bus as main memory.
//  Adds what the single-byte register lacks: address decode, reset, and a hardware clear sweep after reset.
// PARAMETERS
//  WIDTH   8    data word and bus width in bits; WIDTH >= ADDR_W required
//  DEPTH   256  number of words; need not be a power of 2
//  ADDR_W  (localparam) clog2(DEPTH), minimum 1; MAR width
// PORTS
//  clk    in     1      single clock, all state updates on posedge
//  reset  in     1      asynchronous, active-high reset
//  bis    in     WIDTH  input bus: address (sa) or write data (s)
//  sa     in     1      set-address: load MAR from bis[ADDR_W-1:0]
//  s      in     1      set: write bis into mem[MAR]
//  e      in     1      enable: drive mem[MAR] onto bos
//  bos    inout  WIDTH  output bus, high-Z unless driving
//  busy   out    1      high while clear sweep runs
// BEHAVIOUR
//  Reset (async, any time, including mid-sweep or mid-access):
//   - MAR=0, clr_ptr=0, state=CLEAR, busy=1, bos=Z.
//   - Sweep restarts from word 0.
//  FSM states:
//   - CLEAR: each posedge writes mem[clr_ptr]=0 and increments clr_ptr.
//   - CLEAR -> READY: at the edge that writes word DEPTH-1.
//   - busy is 1 for exactly DEPTH posedges after reset release, then 0.
//   - sa, s and e are ignored while busy: no MAR load, no write, bos=Z.
//   - READY: stays in READY until reset.
//  READY operation:
//   - sa=1 at posedge: MAR <= bis[ADDR_W-1:0]. Upper bis bits are ignored.
//   - s=1 at posedge: mem[MAR] <= bis. Write latency is 1 edge.
//   - e=1: bos = mem[MAR] combinationally (async read, zero latency). e=0: bos=Z.
//  Simultaneous events:
//   - sa & s same edge: write uses the pre-edge MAR; MAR then updates.
//   - s & e together: bos shows old word before the edge and the new word after it.
//   - sa & e together: bos shows the old-address word until the edge, then the new-address word.
//  Out-of-range (DEPTH not a power of 2, MAR >= DEPTH):
//   - Writes are dropped.
//   - Reads drive all zeros (bus still driven when e=1).
//  No wrap-around on MAR. clr_ptr stops at DEPTH-1.
//  Memory contents are not reset asynchronously; only the sweep zeroes them.
// STRUCTURE
//  Shared header jdefs.vh:
//   - clog2 constant function.
//   - State encodings: CLEAR=1'b0, READY=1'b1.
//  One natural sub-module, jram_array: WIDTH x DEPTH storage.
//   - Synchronous write port (we, waddr, wdata).
//   - Async read port with out-of-range zeroing.
//   - Top level muxes the write port between the sweep and the s path.
//  Tri-state output reuses the existing jenabler (WIDTH-generalised), with enable = e & ~busy.
//  Top level holds MAR, FSM, clr_ptr and busy.
// TESTING
//  1 Reset sweep: WIDTH=8, DEPTH=16, pulse reset -> busy=1 for exactly 16 posedges, then 0. Every address reads 8'h00.
//  2 Write/read: sa with bis=8'h05, then s with bis=8'hA5, then e=1 -> bos=8'hA5. e=0 -> bos=8'hZZ.
//  3 Same-edge sa+s: MAR=3, edge with sa=1, s=1, bis=8'h07 -> mem[3]=8'h07, MAR=7, mem[7] unchanged.
//  4 Busy gating: assert s=1, e=1, bis=8'hFF during the sweep -> bos=Z, and after sweep all words read 8'h00.
//  5 Mid-sweep reset: reset at sweep cycle 9 -> busy restarts, stays high 16 more edges, MAR=0.
//  6 Out-of-range: DEPTH=12, MAR=13, s with 8'h3C -> no word changes. e=1 -> bos=8'h00.

Source files
------------

// File: rtl/jparam_ram_pkg.sv
// Shared types and helpers for the parametrised bus RAM.
package jparam_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Address width for a given depth, never less than one bit.
  function automatic int unsigned addr_bits(input int unsigned depth);
    int unsigned n;
    n = 0;
    while ((64'd1 << n) < 64'(depth)) n++;
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/jparam_ram_if.sv
// Input-side bus bundle of the RAM: data/address bus, strobes and busy flag.
interface jparam_ram_if #(parameter int unsigned WIDTH = 8);
  logic [WIDTH-1:0] bis;
  logic             sa;
  logic             s;
  logic             e;
  logic             busy;

  modport master (output bis, sa, s, e, input busy);
  modport slave  (input bis, sa, s, e, output busy);
endinterface

// File: rtl/jparam_ram_array.sv
// WIDTH x DEPTH storage: synchronous write, asynchronous read, out-of-range
// addresses drop writes and read back as zero.
module jram_array #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_c = '0;
    if (32'(raddr) < DEPTH) rdata_c = mem[raddr];
  end

endmodule

// File: rtl/jparam_ram_enabler.sv
// Tri-state bus driver: passes the word through when enabled, else releases the bus.
module jenabler #(parameter int unsigned WIDTH = 8) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output wire  [WIDTH-1:0] y
);

  assign y = en ? a : {WIDTH{1'bz}};

endmodule

// File: rtl/jparam_ram.sv
// Bus-attached RAM with memory address register and a post-reset clear sweep.
module jparam_ram
  import jparam_ram_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  jparam_ram_if.slave      bus,
  inout  wire  [WIDTH-1:0] bos
);

  localparam int unsigned ADDR_W = addr_bits(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] mar, mar_nx;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata_c;
  logic              busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      mar     <= '0;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      mar     <= mar_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  // Write port belongs to the sweep while clearing, to the s path once ready.
  always_comb begin
    state_nx   = state;
    mar_nx     = mar;
    clr_ptr_nx = clr_ptr;
    we         = 1'b0;
    waddr      = mar;
    wdata      = bus.bis;
    unique case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_ptr;
        wdata = '0;
        if (clr_ptr == LAST) state_nx = READY;
        else                 clr_ptr_nx = clr_ptr + ADDR_W'(1);
      end
      READY: begin
        if (bus.sa) mar_nx = bus.bis[ADDR_W-1:0];
        we = bus.s;
      end
      default: state_nx = CLEAR;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign bus.busy = busy;

  jram_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr  (mar),
    .rdata_c(rdata_c)
  );

  jenabler #(.WIDTH(WIDTH)) u_enabler (
    .en(bus.e & ~busy),
    .a (rdata_c),
    .y (bos)
  );

endmodule

// File: tb/tb_jparam_ram.sv
// Scoreboard bench for jparam_ram: a 16-word instance and a 12-word instance.
// Released output buses are pulled high, so an undriven bus reads 8'hFF.
module tb_jparam_ram;

  localparam logic [7:0] REL = 8'hFF;

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] bos;
    logic       busy;
  } exp_t;

  logic clk;
  logic reset;
  wire [7:0] bos_a;
  wire [7:0] bos_b;
  exp_t q[$];
  int compared;
  int mismatched;
  bit done;

  jparam_ram_if #(.WIDTH(8)) if_a ();
  jparam_ram_if #(.WIDTH(8)) if_b ();

  jparam_ram #(.WIDTH(8), .DEPTH(16)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .bos(bos_a)
  );

  jparam_ram #(.WIDTH(8), .DEPTH(12)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .bos(bos_b)
  );

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (bos_a[i]);
    pullup (bos_b[i]);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: the stimulus must complete within a bounded time.
  initial begin
    done = 1'b0;
    #50000;
    if (!done) begin
      mismatched++;
      $display("FAIL watchdog: stimulus did not complete in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  // Monitor: every queued expectation is checked at the following negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t       x;
      logic [7:0] act_bos;
      logic       act_busy;
      x        = q.pop_front();
      act_bos  = (x.dut == 0) ? bos_a : bos_b;
      act_busy = (x.dut == 0) ? if_a.busy : if_b.busy;
      compared++;
      if (act_bos !== x.bos || act_busy !== x.busy) begin
        mismatched++;
        $display("FAIL %s (dut %0d): got bos=%h busy=%b, want bos=%h busy=%b",
                 x.name, x.dut, act_bos, act_busy, x.bos, x.busy);
      end
    end
  end

  task automatic push(input string n, input int d, input logic [7:0] b, input logic bz);
    exp_t x;
    x.name = n;
    x.dut  = d;
    x.bos  = b;
    x.busy = bz;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic sa_v, input logic s_v,
                       input logic e_v, input logic [7:0] b);
    if (d == 0) begin
      if_a.sa = sa_v; if_a.s = s_v; if_a.e = e_v; if_a.bis = b;
    end else begin
      if_b.sa = sa_v; if_b.s = s_v; if_b.e = e_v; if_b.bis = b;
    end
  endtask

  task automatic wr(input int d, input logic [7:0] addr, input logic [7:0] data);
    drive(d, 1'b1, 1'b0, 1'b0, addr);
    tick();
    drive(d, 1'b0, 1'b1, 1'b0, data);
    tick();
    drive(d, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic read_chk(input string n, input int d, input logic [7:0] addr,
                          input logic [7:0] expv);
    drive(d, 1'b1, 1'b0, 1'b0, addr);
    tick();
    drive(d, 1'b0, 1'b0, 1'b1, 8'h00);
    push(n, d, expv, 1'b0);
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    #3;
    compared++;
    if (bos_a !== REL || if_a.busy !== 1'b1 || bos_b !== REL || if_b.busy !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_state_now: bos_a=%h busy_a=%b bos_b=%h busy_b=%b",
               bos_a, if_a.busy, bos_b, if_b.busy);
    end
    push("reset_state", 0, REL, 1'b1);
    push("reset_state", 1, REL, 1'b1);
    tick();
    reset = 1'b0;

    // Sweep length: 16 edges for dut a, 12 for dut b.
    for (int k = 1; k <= 16; k++) begin
      tick();
      push("sweep_busy", 0, REL, k < 16);
      push("sweep_busy", 1, REL, k < 12);
    end
    for (int i = 0; i < 16; i++) read_chk("swept_zero", 0, 8'(i), 8'h00);

    // Basic write then read, and bus release.
    wr(0, 8'h05, 8'hA5);
    read_chk("wr_rd", 0, 8'h05, 8'hA5);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    push("e_off", 0, REL, 1'b0);
    tick();

    // sa and s on the same edge: write lands at old MAR.
    drive(0, 1'b1, 1'b0, 1'b0, 8'h03);
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 8'h07);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 8'h00);
    push("sa_s_new_mar", 0, 8'h00, 1'b0);
    tick();
    read_chk("sa_s_old_mar", 0, 8'h03, 8'h07);

    // s with e: old word before the edge, new word after.
    drive(0, 1'b0, 1'b1, 1'b1, 8'h5A);
    push("s_e_before", 0, 8'h07, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 8'h00);
    push("s_e_after", 0, 8'h5A, 1'b0);
    tick();

    // sa with e: old-address word before the edge, new-address word after.
    drive(0, 1'b1, 1'b0, 1'b1, 8'h05);
    push("sa_e_before", 0, 8'h5A, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 8'h00);
    push("sa_e_after", 0, 8'hA5, 1'b0);
    tick();

    // Strobes held during the sweep must be ignored.
    reset = 1'b1;
    drive(0, 1'b0, 1'b1, 1'b1, 8'hFF);
    #2;
    reset = 1'b0;
    push("gate_busy", 0, REL, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) push("gate_busy", 0, REL, 1'b1);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    push("gate_done", 0, REL, 1'b0);
    for (int i = 0; i < 16; i++) read_chk("gate_zero", 0, 8'(i), 8'h00);

    // Reset in the middle of the sweep restarts it from word 0.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      push("pre_mid_busy", 0, REL, 1'b1);
    end
    reset = 1'b1;
    #1;
    push("mid_reset", 0, REL, 1'b1);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      push("restart_busy", 0, REL, k < 16);
      push("restart_busy", 1, REL, k < 12);
    end
    drive(0, 1'b0, 1'b1, 1'b0, 8'hC3);
    tick();
    read_chk("mar_zero", 0, 8'h00, 8'hC3);
    read_chk("mar_zero_nb", 0, 8'h01, 8'h00);

    // Out-of-range on the 12-word instance.
    wr(1, 8'h0B, 8'h66);
    read_chk("b_in_range", 1, 8'h0B, 8'h66);
    wr(1, 8'h0D, 8'h3C);
    read_chk("oor_keep_11", 1, 8'h0B, 8'h66);
    read_chk("oor_keep_1", 1, 8'h01, 8'h00);
    read_chk("oor_read_13", 1, 8'h0D, 8'h00);
    read_chk("oor_read_12", 1, 8'h0C, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
